// File: rtl/std_iic_slave.sv
// std_iic_slave: I2C target that answers one 7-bit address (SLAVE_ADDR).
// Writes from the master appear on rx_data with a one-cycle rx_valid pulse.
// Reads return tx_data, which is sampled with a one-cycle tx_req pulse.
// The block never stretches SCL and only ever pulls SDA low (open drain).
// Optional build macro IIC_SLAVE_GLITCH_FILTER_EN adds a FILT_LEN-deep
// glitch filter on SCL and SDA after the 2-FF synchronizers.
`timescale 1ns/1ps
module std_iic_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h0B,
  parameter int         FILT_LEN   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  // A zero-length filter has no meaning; reject it at elaboration.
  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("std_iic_slave: FILT_LEN must be at least 1");
  end

  logic   scl_s1, scl_s2, sda_s1, sda_s2;
  logic   scl_flt, sda_flt;
  logic   scl_q, sda_q;
  logic   scl_rise, scl_fall, start_det, stop_det;
  state_t state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [6:0] tx_shift;
  logic       rw;
  logic       sda_oe;

  // Two-flop synchronizers; they idle high like the released bus.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses nonblocking assignments so every flop
    // samples the values from before the edge, forming a true shift chain.
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
    end
  end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);
  logic [FCW-1:0] scl_cnt, sda_cnt;

  // Filtered level follows the synchronized level only after it has
  // disagreed for FILT_LEN consecutive samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_flt <= 1'b1;
      sda_flt <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s2 == scl_flt) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FCW'(FILT_LEN - 1)) begin
        scl_flt <= scl_s2;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_s2 == sda_flt) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FCW'(FILT_LEN - 1)) begin
        sda_flt <= sda_s2;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end
`else
  assign scl_flt = scl_s2;
  assign sda_flt = sda_s2;
`endif

  // Previous filtered levels, used to find edges and bus conditions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_flt;
      sda_q <= sda_flt;
    end
  end

  assign scl_rise  =  scl_flt & ~scl_q;
  assign scl_fall  = ~scl_flt &  scl_q;
  assign start_det =  scl_flt &  scl_q &  sda_q & ~sda_flt;
  assign stop_det  =  scl_flt &  scl_q & ~sda_q &  sda_flt;

  // Open drain: only ever pull low, otherwise release to the pull-up.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Protocol FSM; START/STOP override every state. In the ACK states
  // bit_cnt[0] marks whether the ACK low has already been applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_oe <= 1'b0;
          end
          ADDR: begin
            if (scl_rise) begin
              rx_shift <= {rx_shift[5:0], sda_flt};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                if (rx_shift == SLAVE_ADDR) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                  rw    <= sda_flt;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!bit_cnt[0]) begin
                sda_oe  <= 1'b1;
                bit_cnt <= 3'd1;
              end else begin
                bit_cnt <= '0;
                if (rw) begin
                  state    <= RD_BYTE;
                  tx_req   <= 1'b1;
                  tx_shift <= tx_data[6:0];
                  sda_oe   <= ~tx_data[7];
                end else begin
                  state  <= WR_BYTE;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              rx_shift <= {rx_shift[5:0], sda_flt};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                bit_cnt  <= '0;
                rx_data  <= {rx_shift, sda_flt};
                rx_valid <= 1'b1;
                state    <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!bit_cnt[0]) begin
                sda_oe  <= 1'b1;
                bit_cnt <= 3'd1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= WR_BYTE;
              end
            end
          end
          RD_BYTE: begin
            // Bit 7 went out on entry; each later falling edge shifts one.
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= RD_ACK;
              end else begin
                sda_oe   <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            // A NACK leaves on the rising edge, so a falling edge here
            // always follows a master ACK.
            if (scl_rise && sda_flt) begin
              state <= WAIT_STOP;
            end else if (scl_fall) begin
              state    <= RD_BYTE;
              bit_cnt  <= '0;
              tx_req   <= 1'b1;
              tx_shift <= tx_data[6:0];
              sda_oe   <= ~tx_data[7];
            end
          end
          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_std_iic_slave.sv
// tb_std_iic_slave: bit-banged I2C master driving std_iic_slave, with
// table-driven write vectors, hand-written corner sequences, and random
// transactions checked against a transaction-level expectation model.
`timescale 1ns/1ps
module tb_std_iic_slave;

  localparam logic [6:0] ADDR = 7'h0B;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl   = 1'b1;
  logic       m_oe  = 1'b0;
  wire        sda;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int q        = 10;  // quarter SCL period in clk cycles

  always #10 clk = ~clk;  // 50 MHz

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  std_iic_slave #(.SLAVE_ADDR(ADDR), .FILT_LEN(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  // Observers: received bytes, tx_req count, slave pulls, pulse widths.
  logic [7:0] rx_q[$];
  logic [7:0] tx_plan[$];
  logic [7:0] tx_rand = 8'h00;
  int tx_req_cnt = 0, slave_low_cnt = 0, rv_run = 0, rv_max = 0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rv_run++;
      if (rv_run > rv_max) rv_max = rv_run;
    end else begin
      rv_run = 0;
    end
    if (tx_req) begin
      tx_req_cnt++;
      if (tx_plan.size() != 0) void'(tx_plan.pop_front());
      tx_rand = 8'($urandom);
    end
    if (!m_oe && sda === 1'b0) slave_low_cnt++;
    tx_data = (tx_plan.size() != 0) ? tx_plan[0] : tx_rand;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    m_oe = 1'b0; tick(q);
    scl  = 1'b1; tick(q);
    m_oe = 1'b1; tick(q);
    scl  = 1'b0; tick(q);
  endtask

  task automatic m_stop();
    m_oe = 1'b1; tick(q);
    scl  = 1'b1; tick(q);
    m_oe = 1'b0; tick(q);
  endtask

  task automatic m_bit(input logic b, output logic s);
    m_oe = ~b;   tick(q);
    scl  = 1'b1; tick(q);
    s    = sda;  tick(q);
    scl  = 1'b0; tick(q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(~ack, s);
  endtask

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } wr_vec_t;

  wr_vec_t vecs[5];

  initial begin
    logic       ack, s;
    logic [7:0] d, got;
    int         req0;

    vecs[0] = '{8'h20, 8'h11, 8'h00, 1'b0};  // address 0x10: not us
    vecs[1] = '{8'h16, 8'h00, 8'hFF, 1'b1};
    vecs[2] = '{8'h14, 8'h55, 8'hAA, 1'b0};  // address 0x0A: off by one
    vecs[3] = '{8'h16, 8'h80, 8'h01, 1'b1};
    vecs[4] = '{8'h96, 8'h12, 8'h34, 1'b0};  // address 0x4B: top bit differs

    // Reset state
    tick(3);
    check("reset_busy", busy, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_req", tx_req, 0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_sda_released", sda, 1);
    rst_n = 1'b1;
    tick(4);

    // Two-byte write at ~400 kHz
    q = 31;
    rx_q.delete();
    m_start();
    send_byte(8'h16, ack); check("w400_addr_ack", ack, 1);
    check("w400_busy", busy, 1);
    send_byte(8'hA5, ack); check("w400_ack0", ack, 1);
    send_byte(8'h3C, ack); check("w400_ack1", ack, 1);
    m_stop(); tick(4);
    check("w400_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("w400_rx0", rx_q[0], 8'hA5);
      check("w400_rx1", rx_q[1], 8'h3C);
    end
    check("w400_busy_after_stop", busy, 0);

    // Two-byte read, master ACK then NACK
    tx_plan.push_back(8'h5A);
    tx_plan.push_back(8'hC3);
    tick(2);
    req0 = tx_req_cnt;
    m_start();
    send_byte(8'h17, ack); check("r400_addr_ack", ack, 1);
    recv_byte(1'b1, got); check("r400_byte0", got, 8'h5A);
    recv_byte(1'b0, got); check("r400_byte1", got, 8'hC3);
    check("r400_tx_req_count", tx_req_cnt - req0, 2);
    m_bit(1'b1, s); check("r400_wait_stop_released", s, 1);
    check("r400_no_extra_req", tx_req_cnt - req0, 2);
    m_stop(); tick(4);
    check("r400_busy_after_stop", busy, 0);
    q = 10;

    // Table-driven writes, including address mismatches
    for (int v = 0; v < 5; v++) begin
      rx_q.delete();
      slave_low_cnt = 0;
      m_start();
      send_byte(vecs[v].addr_byte, ack); check("tbl_addr_ack", ack, vecs[v].exp_ack);
      check("tbl_busy", busy, vecs[v].exp_ack);
      send_byte(vecs[v].d0, ack); check("tbl_ack0", ack, vecs[v].exp_ack);
      send_byte(vecs[v].d1, ack); check("tbl_ack1", ack, vecs[v].exp_ack);
      m_stop(); tick(4);
      check("tbl_busy_after_stop", busy, 0);
      check("tbl_slave_pulled_low", slave_low_cnt != 0, vecs[v].exp_ack);
      check("tbl_rx_count", rx_q.size(), vecs[v].exp_ack ? 2 : 0);
      if (vecs[v].exp_ack && rx_q.size() == 2) begin
        check("tbl_rx0", rx_q[0], vecs[v].d0);
        check("tbl_rx1", rx_q[1], vecs[v].d1);
      end
    end

    // Repeated START: write one byte, then read one byte
    rx_q.delete();
    tx_plan.push_back(8'h9E);
    tick(2);
    req0 = tx_req_cnt;
    m_start();
    send_byte(8'h16, ack); check("rs_addr_w_ack", ack, 1);
    send_byte(8'h07, ack); check("rs_data_ack", ack, 1);
    m_start();
    send_byte(8'h17, ack); check("rs_addr_r_ack", ack, 1);
    check("rs_busy", busy, 1);
    recv_byte(1'b0, got); check("rs_read_byte", got, 8'h9E);
    m_stop(); tick(4);
    check("rs_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("rs_rx0", rx_q[0], 8'h07);
    check("rs_tx_req_count", tx_req_cnt - req0, 1);
    check("rs_busy_after_stop", busy, 0);

    // STOP after the 4th bit of a data byte
    rx_q.delete();
    m_start();
    send_byte(8'h16, ack); check("abort_addr_ack", ack, 1);
    for (int i = 7; i >= 4; i--) m_bit(1'b1, s);
    m_stop(); tick(3);
    check("abort_sda_released", sda, 1);
    check("abort_busy", busy, 0);
    check("abort_no_rx_valid", rx_q.size(), 0);
    m_start();
    send_byte(8'h16, ack); check("abort_next_addr_ack", ack, 1);
    send_byte(8'h42, ack); check("abort_next_ack", ack, 1);
    m_stop(); tick(4);
    check("abort_next_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("abort_next_rx0", rx_q[0], 8'h42);

    // rst_n asserted in the middle of a read while the slave pulls low
    rx_q.delete();
    tx_plan.push_back(8'h00);
    tick(2);
    req0 = tx_req_cnt;
    m_start();
    send_byte(8'h17, ack); check("rstrd_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) m_bit(1'b1, s);
    check("rstrd_slave_driving", sda, 0);
    rst_n = 1'b0;
    tick(3);
    check("rstrd_sda_released", sda, 1);
    check("rstrd_busy", busy, 0);
    check("rstrd_tx_req_count", tx_req_cnt - req0, 1);
    rst_n = 1'b1;
    tick(2);
    scl = 1'b1;
    tick(q);
    m_start();
    send_byte(8'h16, ack); check("rstrd_next_addr_ack", ack, 1);
    send_byte(8'h5C, ack); check("rstrd_next_ack", ack, 1);
    m_stop(); tick(4);
    check("rstrd_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("rstrd_rx0", rx_q[0], 8'h5C);

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    // One-clk SCL spike inside a data byte must not count as a bit
    rx_q.delete();
    m_start();
    send_byte(8'h16, ack); check("glitch_addr_ack", ack, 1);
    d = 8'h6B;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) begin
        m_oe = ~d[i]; tick(q / 2);
        scl = 1'b1; tick(1);
        scl = 1'b0; tick(q - q / 2 - 1);
        scl = 1'b1; tick(2 * q);
        scl = 1'b0; tick(q);
      end else begin
        m_bit(d[i], s);
      end
    end
    m_bit(1'b1, s); check("glitch_ack", ~s, 1);
    m_stop(); tick(4);
    check("glitch_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("glitch_rx0", rx_q[0], 8'h6B);
`endif

    // Random transactions against a transaction-level expectation model
    for (int t = 0; t < 16; t++) begin
      logic [6:0] a;
      logic       rw, ok;
      int         n;
      logic [7:0] exp_rx[$];
      logic [7:0] exp_tx[$];
      a  = ($urandom_range(3) == 0) ? 7'($urandom) : ADDR;
      rw = 1'($urandom);
      n  = $urandom_range(1, 3);
      ok = (a == ADDR);
      rx_q.delete();
      exp_rx.delete();
      exp_tx.delete();
      if (ok && rw) begin
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          tx_plan.push_back(d);
          exp_tx.push_back(d);
        end
      end
      tick(2);
      req0 = tx_req_cnt;
      m_start();
      send_byte({a, rw}, ack); check("rnd_addr_ack", ack, ok);
      for (int k = 0; k < n; k++) begin
        if (rw) begin
          recv_byte(k != n - 1, got);
          check("rnd_rd_data", got, ok ? exp_tx[k] : 8'hFF);
        end else begin
          d = 8'($urandom);
          if (ok) exp_rx.push_back(d);
          send_byte(d, ack); check("rnd_wr_ack", ack, ok);
        end
      end
      m_stop(); tick(4);
      check("rnd_busy_idle", busy, 0);
      check("rnd_rx_count", rx_q.size(), exp_rx.size());
      for (int k = 0; k < exp_rx.size(); k++)
        if (k < rx_q.size()) check("rnd_rx_data", rx_q[k], exp_rx[k]);
      check("rnd_tx_req_count", tx_req_cnt - req0, (ok && rw) ? n : 0);
    end

    check("rx_valid_pulse_width", rv_max, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
